// File: rtl/instr_fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM read port, redirect input and decode handshake of the fetch stage
//   master: fetch stage (drives imem_re/imem_addr, out_*, fetch_fault)
//   slave:  environment (ROM, branch unit, decode)
interface instr_fetch_if;
    logic        imem_re;
    logic [29:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;
    modport master (
        output imem_re, imem_addr, out_valid, out_instr, out_pc, fetch_fault,
        input  imem_rd, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_re, imem_addr, out_valid, out_instr, out_pc, fetch_fault,
        output imem_rd, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: circular buffer of fetched {pc, instr} entries
//   push/din write at the tail, pop removes the head, flush empties it,
//   count is the occupancy, head is the oldest entry; async active-high rst
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);
    logic [PW-1:0] rd_ptr, wr_ptr;
    fetch_entry_t  mem [DEPTH];

    // pointers wrap explicitly so any depth works, not just powers of two
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, reads the instruction ROM and buffers words for decode
//   clk, rst (async active-high), bus (instr_fetch_if.master):
//   ROM port imem_re/imem_addr/imem_rd, redirect_valid/redirect_pc,
//   out_valid/out_ready/out_instr/out_pc toward decode, fetch_fault
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state, state_nx;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    fetch_entry_t  head, shown;
    logic          push, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            shown    <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= bus.redirect_valid ? bus.redirect_pc : push ? fetch_pc + PC_STEP : fetch_pc;
            // remember what decode last saw so out_* hold while the buffer is empty
            if (bus.out_valid) shown <= head;
        end
    end

    always_comb begin
        state_nx = bus.redirect_valid ? ((bus.redirect_pc[1:0] == 2'b00) ? RUN : FAULT)
                                      : ((state == IDLE) ? RUN : state);
        push     = (state == RUN) && !bus.redirect_valid && (count < CW'(FIFO_DEPTH));
        pop      = bus.out_valid && bus.out_ready && !bus.redirect_valid;
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   ('{pc: fetch_pc, instr: bus.imem_rd}),
        .count (count),
        .head  (head)
    );

    assign bus.imem_re     = push;
    assign bus.imem_addr   = fetch_pc[31:2];
    assign bus.out_valid   = count != '0;
    assign bus.out_instr   = bus.out_valid ? head.instr : shown.instr;
    assign bus.out_pc      = bus.out_valid ? head.pc : shown.pc;
    assign bus.fetch_fault = state == FAULT;
endmodule
